mux4_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 4:1 mux datapath among four requesters.
- Owns the mux select lines s1/s0 and a one-entry registered output stage with a valid/ready handshake to the downstream consumer.
- Sits in front of the 4:1 mux in the dataflow path. It replaces static select stimulus with fair, burst-limited arbitration.

---
 rtl/mux4_rr_sched_pkg.sv | 28 ++
 rtl/mux4_rr_sched_data.sv | 16 +
 rtl/mux4_rr_sched.sv | 107 ++++++++++
 tb/tb_mux4_rr_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_sched_pkg.sv
// Shared definitions for the round-robin 4:1 mux scheduler: state encoding,
// requester/select/counter widths and the rotating-priority search.
package mux4_rr_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 4;

  // First requester with req set, searching ptr, ptr+1, ... modulo 4.
  // The loop runs from the farthest offset down, so the nearest hit wins.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux4_rr_sched_data.sv
// Shared 4:1 datapath mux: picks one DATA_W-bit word out of four by {s1,s0}.
module mux4_data #(
  parameter int DATA_W = 8
) (
  input  logic                  s1,
  input  logic                  s0,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [DATA_W-1:0]     out_data
);

  // Word select driven by the scheduler's select lines.
  always_comb begin
    out_data = in_data[{s1, s0}*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin, burst-limited scheduler in front of a shared 4:1 mux with a
// one-entry registered output stage and a valid/ready downstream handshake.
module mux4_rr_sched
  import mux4_rr_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   in_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        s1,
  output logic                        s0,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic                        busy
);

  logic [0:0]        state_reg;
  logic [SEL_W-1:0]  ptr_reg;
  logic [SEL_W-1:0]  owner_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;

  logic [DATA_W-1:0] mux_word;
  logic [SEL_W-1:0]  winner;
  logic              load_en;
  logic              in_grant;
  logic              beat;
  logic              last_beat;
  logic              rel_now;

  // Select lines follow the registered owner, so they hold through IDLE.
  assign s1 = owner_reg[1];
  assign s0 = owner_reg[0];

  mux4_data #(
    .DATA_W   (DATA_W)
  ) u_mux (
    .s1       (s1),
    .s0       (s0),
    .in_data  (in_data),
    .out_data (mux_word)
  );

  // Beat acceptance and release decisions for the current cycle.
  always_comb begin
    load_en   = !out_valid_reg || out_ready;
    in_grant  = (state_reg == GRANT);
    beat      = in_grant && req[owner_reg] && load_en;
    last_beat = beat && ((cnt_reg + CNT_W'(1)) == CNT_W'(MAX_BURST));
    rel_now   = in_grant && (!req[owner_reg] || last_beat);
    winner    = rr_pick(req, ptr_reg);
    gnt       = beat ? (NUM_REQ'(1) << owner_reg) : '0;
  end

  assign busy      = in_grant;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // Output register: load on an accepted beat, drain when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (beat) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= mux_word;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Arbitration FSM: pick an owner in IDLE, stream its burst in GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            owner_reg <= winner;
            cnt_reg   <= '0;
            state_reg <= GRANT;
          end
        end
        default: begin
          if (rel_now) begin
            state_reg <= IDLE;
            ptr_reg   <= owner_reg + SEL_W'(1);
            cnt_reg   <= '0;
          end else if (beat) begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Self-checking bench for mux4_rr_sched. Instance 0 uses MAX_BURST=4,
// instance 1 uses MAX_BURST=1; each has its own stimulus and reference model.
module tb_mux4_rr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [1:0][3:0]  req_v = '0;
  logic [1:0][31:0] din_v = '0;
  logic [1:0]       rdy_v = '0;

  logic [3:0] gnt0, gnt1;
  logic       s1_0, s0_0, s1_1, s0_1;
  logic       ov0, ov1, busy0, busy1;
  logic [7:0] od0, od1;

  mux4_rr_sched #(.DATA_W(8), .MAX_BURST(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .in_data(din_v[0]),
    .gnt(gnt0), .s1(s1_0), .s0(s0_0), .out_valid(ov0), .out_data(od0),
    .out_ready(rdy_v[0]), .busy(busy0)
  );

  mux4_rr_sched #(.DATA_W(8), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .in_data(din_v[1]),
    .gnt(gnt1), .s1(s1_1), .s0(s0_1), .out_valid(ov1), .out_data(od1),
    .out_ready(rdy_v[1]), .busy(busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: owner as an integer (-1 = nobody owns the mux),
  // next search start, beats in the current burst, and the output slot.
  int         mb [2] = '{4, 1};
  int         m_own [2];
  int         m_sel [2];
  int         m_nxt [2];
  int         m_beats [2];
  bit         m_ov [2];
  logic [7:0] m_od [2];
  logic [3:0] exp_gnt [2];
  logic [3:0] last_gnt [2];
  string      fld [5] = '{"gnt", "sel", "busy", "out_valid", "out_data"};

  logic [7:0] xq0 [$];
  logic [7:0] xq1 [$];
  int         xc1 [$];
  int         xc0 [$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_sel[k] = 0; m_nxt[k] = 0; m_beats[k] = 0;
      m_ov[k] = 1'b0; m_od[k] = '0; exp_gnt[k] = '0; last_gnt[k] = '0;
    end
  endtask

  // One clock: compare both DUTs against the model at the falling edge,
  // advance the model, then return 1 time unit after the rising edge.
  // With adv set, a granted requester presents its next word (old + 1).
  task automatic cycle(input bit adv);
    logic [31:0] obs [5];
    logic [31:0] ex  [5];
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      int         o;
      bit         ld;
      bit         acc;
      bit         found;
      logic [3:0] eg;
      o  = m_own[k];
      ld = !m_ov[k] || rdy_v[k];
      eg = (o >= 0 && req_v[k][o] && ld) ? (4'b0001 << o) : 4'b0000;
      exp_gnt[k] = eg;
      obs[0] = (k == 0) ? 32'(gnt0) : 32'(gnt1);
      obs[1] = (k == 0) ? 32'({s1_0, s0_0}) : 32'({s1_1, s0_1});
      obs[2] = (k == 0) ? 32'(busy0) : 32'(busy1);
      obs[3] = (k == 0) ? 32'(ov0) : 32'(ov1);
      obs[4] = (k == 0) ? 32'(od0) : 32'(od1);
      ex[0] = 32'(eg);
      ex[1] = 32'(m_sel[k]);
      ex[2] = (o >= 0) ? 32'd1 : 32'd0;
      ex[3] = 32'(m_ov[k]);
      ex[4] = 32'(m_od[k]);
      for (int j = 0; j < 5; j++) begin
        n_checks++;
        if (obs[j] !== ex[j]) begin
          n_fail++;
          $display("FAIL model_%s dut%0d cyc=%0d got=%0h exp=%0h", fld[j], k, cyc, obs[j], ex[j]);
        end
      end
      last_gnt[k] = obs[0][3:0];
      if (k == 0 && ov0 && rdy_v[0]) begin xq0.push_back(od0); xc0.push_back(cyc); end
      if (k == 1 && ov1 && rdy_v[1]) begin xq1.push_back(od1); xc1.push_back(cyc); end
      // advance model by one clock
      acc = (eg != 0);
      if (acc) begin
        m_od[k] = din_v[k][o*8 +: 8];
        m_ov[k] = 1'b1;
        m_beats[k]++;
      end else if (m_ov[k] && rdy_v[k]) begin
        m_ov[k] = 1'b0;
      end
      if (o < 0) begin
        found = 1'b0;
        for (int t = 0; t < 4; t++) begin
          int idx;
          idx = (m_nxt[k] + t) % 4;
          if (!found && req_v[k][idx]) begin
            found = 1'b1; m_own[k] = idx; m_sel[k] = idx; m_beats[k] = 0;
          end
        end
      end else if (!req_v[k][o] || (acc && m_beats[k] == mb[k])) begin
        m_nxt[k] = (o + 1) % 4; m_own[k] = -1; m_beats[k] = 0;
      end
    end
    @(posedge clk);
    #1;
    if (adv) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 4; i++)
          if (exp_gnt[k][i]) din_v[k][i*8 +: 8] = din_v[k][i*8 +: 8] + 8'd1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_v = '0;
    rdy_v = 2'b11;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    xq0.delete(); xq1.delete(); xc0.delete(); xc1.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_v[0] = 4'b1111; req_v[1] = 4'b1111; rdy_v = 2'b11;
    #2;
    n_checks += 4;
    if (gnt0 !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt0); end
    if ({s1_0, s0_0} !== 2'b00) begin n_fail++; $display("FAIL reset_sel got=%b exp=00", {s1_0, s0_0}); end
    if (ov0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", ov0); end
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    model_reset();
    @(posedge clk);
    #1;
    req_v[0] = 4'b0001; req_v[1] = 4'b0000;
    din_v[0] = 32'h0000_0055;
    rst_n = 1'b1;
    cycle(0);
    n_checks += 2;
    if (gnt0 !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt0); end
    if (ov0 !== 1'b0) begin n_fail++; $display("FAIL reset_early_valid got=%b exp=0", ov0); end
    cycle(0);
    n_checks += 2;
    if (ov0 !== 1'b1) begin n_fail++; $display("FAIL reset_first_valid got=%b exp=1", ov0); end
    if (od0 !== 8'h55) begin n_fail++; $display("FAIL reset_first_data got=%h exp=55", od0); end
    req_v[0] = 4'b0000;
    repeat (3) cycle(0);
    $display("test_reset done checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_seq [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    do_reset();
    req_v[1] = 4'b1111;
    din_v[1] = 32'hA3A2_A1A0;
    for (int n = 0; n < 40 && xq1.size() < 5; n++) cycle(0);
    n_checks++;
    if (xq1.size() < 5) begin
      n_fail++; $display("FAIL rr_beat_count got=%0d exp=5", xq1.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (xq1[i] !== exp_seq[i]) begin n_fail++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, xq1[i], exp_seq[i]); end
        $display("rr beat %0d data=%h", i, xq1[i]);
      end
      for (int i = 1; i < 5; i++) begin
        n_checks++;
        if (xc1[i] - xc1[i-1] != 2) begin n_fail++; $display("FAIL rr_spacing[%0d] got=%0d exp=2", i, xc1[i] - xc1[i-1]); end
      end
    end
    req_v[1] = 4'b0000;
    repeat (3) cycle(0);
  endtask

  task automatic test_burst_limit();
    logic [7:0] exp_seq [9] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h11, 8'h11, 8'h11, 8'h11, 8'h10};
    int         exp_gap [9] = '{0, 1, 1, 1, 2, 1, 1, 1, 2};
    do_reset();
    req_v[0] = 4'b0011;
    din_v[0] = 32'h0000_1110;
    for (int n = 0; n < 60 && xq0.size() < 9; n++) cycle(0);
    n_checks++;
    if (xq0.size() < 9) begin
      n_fail++; $display("FAIL burst_beat_count got=%0d exp=9", xq0.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (xq0[i] !== exp_seq[i]) begin n_fail++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, xq0[i], exp_seq[i]); end
        if (i > 0) begin
          n_checks++;
          if (xc0[i] - xc0[i-1] != exp_gap[i]) begin
            n_fail++; $display("FAIL burst_gap[%0d] got=%0d exp=%0d", i, xc0[i] - xc0[i-1], exp_gap[i]);
          end
        end
        $display("burst beat %0d data=%h", i, xq0[i]);
      end
    end
    req_v[0] = 4'b0000;
    repeat (3) cycle(0);
  endtask

  task automatic test_stall();
    logic [7:0] held;
    logic [7:0] exp_seq [4] = '{8'h20, 8'h21, 8'h22, 8'h23};
    do_reset();
    req_v[0] = 4'b0100;
    din_v[0] = 32'h0020_0000;
    for (int n = 0; n < 20 && xq0.size() < 2; n++) cycle(1);
    rdy_v[0] = 1'b0;
    held = od0;
    for (int n = 0; n < 3; n++) begin
      cycle(1);
      n_checks += 2;
      if (last_gnt[0] !== 4'b0000) begin n_fail++; $display("FAIL stall_gnt got=%b exp=0000", last_gnt[0]); end
      if (od0 !== held) begin n_fail++; $display("FAIL stall_data got=%h exp=%h", od0, held); end
    end
    rdy_v[0] = 1'b1;
    for (int n = 0; n < 20 && xq0.size() < 4; n++) cycle(1);
    n_checks++;
    if (xq0.size() < 4) begin
      n_fail++; $display("FAIL stall_beat_count got=%0d exp=4", xq0.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (xq0[i] !== exp_seq[i]) begin n_fail++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, xq0[i], exp_seq[i]); end
        $display("stall beat %0d data=%h", i, xq0[i]);
      end
    end
    req_v[0] = 4'b0000;
    repeat (3) cycle(0);
  endtask

  task automatic test_early_release();
    int g = 0;
    do_reset();
    req_v[0] = 4'b0010;
    din_v[0] = 32'h0000_3000;
    for (int n = 0; n < 20 && g < 2; n++) begin
      cycle(1);
      if (last_gnt[0] == 4'b0010) g++;
    end
    req_v[0] = 4'b0000;
    repeat (2) cycle(0);
    req_v[0] = 4'b1011;
    din_v[0] = 32'hD300_D1D0;
    last_gnt[0] = 4'b0000;
    for (int n = 0; n < 10 && last_gnt[0] == 4'b0000; n++) cycle(0);
    n_checks++;
    if (last_gnt[0] !== 4'b1000) begin n_fail++; $display("FAIL early_next_gnt got=%b exp=1000", last_gnt[0]); end
    $display("early release next gnt=%b", last_gnt[0]);
    req_v[0] = 4'b0000;
    repeat (3) cycle(0);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_v[0] = 4'b0100;
    din_v[0] = 32'h0040_0000;
    repeat (3) cycle(1);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (gnt0 !== 4'b0000) begin n_fail++; $display("FAIL midrst_gnt got=%b exp=0000", gnt0); end
    if ({s1_0, s0_0} !== 2'b00) begin n_fail++; $display("FAIL midrst_sel got=%b exp=00", {s1_0, s0_0}); end
    if (ov0 !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", ov0); end
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy0); end
    if (od0 !== 8'h00) begin n_fail++; $display("FAIL midrst_out_data got=%h exp=00", od0); end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_v[0] = 4'b1111;
    din_v[0] = 32'h5352_5150;
    for (int n = 0; n < 10 && last_gnt[0] == 4'b0000; n++) cycle(0);
    n_checks++;
    if (last_gnt[0] !== 4'b0001) begin n_fail++; $display("FAIL midrst_restart_gnt got=%b exp=0001", last_gnt[0]); end
    $display("reset mid-burst restart gnt=%b", last_gnt[0]);
    req_v[0] = 4'b0000;
    repeat (3) cycle(0);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < 2; k++) begin
        rdy_v[k] = ($urandom_range(0, 9) < 7);
        for (int i = 0; i < 4; i++) begin
          if (req_v[k][i]) begin
            if (exp_gnt[k][i]) begin
              if ($urandom_range(0, 2) == 0) req_v[k][i] = 1'b0;
              din_v[k][i*8 +: 8] = 8'($urandom);
            end
          end else if ($urandom_range(0, 3) == 0) begin
            req_v[k][i] = 1'b1;
            din_v[k][i*8 +: 8] = 8'($urandom);
          end
        end
      end
      cycle(0);
    end
    $display("random done beats0=%0d beats1=%0d", xq0.size(), xq1.size());
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_burst_limit();
    test_stall();
    test_early_release();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
